// File: rtl/axil_master.sv
// AXI-Lite master: turns one command at a time into an AW/W/B or AR/R exchange
// and returns the outcome on a response handshake. It also counts error responses.
module axil_master #(
    parameter int ERR_W = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    // command in
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic             cmdWrite,
    input  logic [31:0]      cmdAddr,
    input  logic [31:0]      cmdData,
    input  logic [3:0]       cmdStrb,
    input  logic [2:0]       cmdProt,
    // response out
    output logic             rspValid,
    input  logic             rspReady,
    output logic             rspWrite,
    output logic [31:0]      rspData,
    output logic [1:0]       rspResp,
    // AXI-Lite write address / data / response
    output logic [31:0]      awAddr,
    output logic [2:0]       awProt,
    output logic             awValid,
    input  logic             awReady,
    output logic [31:0]      wData,
    output logic [3:0]       wStrb,
    output logic             wValid,
    input  logic             wReady,
    input  logic [1:0]       bResp,
    input  logic             bValid,
    output logic             bReady,
    // AXI-Lite read address / data
    output logic [31:0]      arAddr,
    output logic [2:0]       arProt,
    output logic             arValid,
    input  logic             arReady,
    input  logic [31:0]      rData,
    input  logic [1:0]       rResp,
    input  logic             rValid,
    output logic             rReady,
    // status
    output logic             busy,
    output logic [ERR_W-1:0] errCount
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_RSP   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic             aw_pend_q, aw_pend_d;
    logic             w_pend_q, w_pend_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [3:0]       strb_q, strb_d;
    logic [2:0]       prot_q, prot_d;
    logic             rsp_write_q, rsp_write_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_resp_q, rsp_resp_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             resp_hs;
    logic [1:0]       resp_code;

    // NOTE: every variable written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        aw_pend_d   = aw_pend_q;
        w_pend_d    = w_pend_q;
        addr_d      = addr_q;
        data_d      = data_q;
        strb_d      = strb_q;
        prot_d      = prot_q;
        rsp_write_d = rsp_write_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        err_d       = err_q;
        resp_hs     = 1'b0;
        resp_code   = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (cmdValid) begin
                    addr_d = cmdAddr;
                    data_d = cmdData;
                    strb_d = cmdStrb;
                    prot_d = cmdProt;
                    if (cmdWrite) begin
                        state_d   = S_WRITE;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
                // AW and W retire independently; move on once neither is left
                aw_pend_d = aw_pend_q && !awReady;
                w_pend_d  = w_pend_q && !wReady;
                if (!(aw_pend_q && !awReady) && !(w_pend_q && !wReady)) begin
                    state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (bValid) begin
                    state_d     = S_RSP;
                    rsp_write_d = 1'b1;
                    rsp_data_d  = 32'h0;
                    rsp_resp_d  = bResp;
                    resp_hs     = 1'b1;
                    resp_code   = bResp;
                end
            end
            S_READ: begin
                if (arReady) begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (rValid) begin
                    state_d     = S_RSP;
                    rsp_write_d = 1'b0;
                    rsp_data_d  = rData;
                    rsp_resp_d  = rResp;
                    resp_hs     = 1'b1;
                    resp_code   = rResp;
                end
            end
            S_RSP: begin
                if (rspReady) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (resp_hs && resp_code != 2'b00 && err_q != {ERR_W{1'b1}}) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples the
    // pre-edge value of every other flop, matching real hardware.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            aw_pend_q   <= 1'b0;
            w_pend_q    <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_resp_q  <= 2'b00;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            aw_pend_q   <= aw_pend_d;
            w_pend_q    <= w_pend_d;
            rsp_write_q <= rsp_write_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the command payload is left out of reset; it is only observed behind a
    // valid that is itself reset, so clearing it would buy nothing.
    always_ff @(posedge aclk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        strb_q <= strb_d;
        prot_q <= prot_d;
    end

    // aresetn gates cmdReady so no command is offered while reset is held
    assign cmdReady = (state_q == S_IDLE) && aresetn;
    assign busy     = (state_q != S_IDLE);

    assign awValid  = aw_pend_q;
    assign awAddr   = addr_q;
    assign awProt   = prot_q;
    assign wValid   = w_pend_q;
    assign wData    = data_q;
    assign wStrb    = strb_q;
    assign bReady   = (state_q == S_WRESP);

    assign arValid  = (state_q == S_READ);
    assign arAddr   = addr_q;
    assign arProt   = prot_q;
    assign rReady   = (state_q == S_RDATA);

    assign rspValid = (state_q == S_RSP);
    assign rspWrite = rsp_write_q;
    assign rspData  = rsp_data_q;
    assign rspResp  = rsp_resp_q;
    assign errCount = err_q;

endmodule
